output_writer: RTL and testbench
================================

OUTPUT_WRITER -- requirements
Module: output_writer

Interface
REQ-001 SHALL have parameter WORD, default 8, pixel and dimension width.
REQ-002 SHALL have parameter DEPTH, default 4, elastic FIFO depth (power of two).
REQ-003 SHALL have a single clock and an asynchronous, active-high reset: clk input 1, rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse beginning a frame write.
REQ-006 h  input  WORD  frame height in rows, unsigned, sampled at start.
REQ-007 w  input  WORD  frame width in columns, unsigned, sampled at start.
REQ-008 base_addr  input  WORD+1  first output-memory address, sampled at start.
REQ-009 in_data  input  WORD  filtered pixel from the filter core.
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  block accepts in_data this cycle.
REQ-012 mem_grant  input  1  shared memory port granted to this block this cycle.
REQ-013 w_addr  output  WORD+1  output-memory write address.
REQ-014 w_data  output  WORD  output-memory write data.
REQ-015 w_en  output  1  write strobe.
REQ-016 busy  output  1  high in RUN and DRAIN.
REQ-017 done  output  1  one-cycle pulse when the last pixel is written.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE->RUN on start with h!=0 and w!=0; IDLE->DONE on start with h==0 or w==0; start outside IDLE SHALL be ignored.
REQ-020 On IDLE->RUN: latch total=h*w (2*WORD bits unsigned), base_addr; clear accept and write counters.
REQ-021 Accept (push) SHALL occur when in_valid and in_ready; in_ready = (state==RUN) and FIFO not full; no bypass when full.
REQ-022 RUN->DRAIN in the cycle after the accept that makes accept count equal total; in_ready SHALL be low from that cycle on.
REQ-023 Write (pop) SHALL occur when state is RUN or DRAIN, FIFO not empty, and mem_grant; w_en is combinational from these terms.
REQ-024 w_data SHALL equal the FIFO head; w_addr SHALL equal base_addr + write count, modulo 2^(WORD+1) (wrap-around, no error).
REQ-025 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-026 DRAIN->DONE on the pop that makes write count equal total; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-027 FIFO order SHALL be strict first-in-first-out; no pixel dropped or duplicated.
REQ-028 In IDLE and DONE: in_ready=0, w_en=0; w_addr and w_data SHALL hold last values (don't-care for the memory).
REQ-029 Pop with mem_grant low SHALL stall without data loss; upstream sees in_ready low once FIFO is full.

Reset
REQ-030 rst high SHALL, asynchronously, force state IDLE, FIFO empty, all counters 0, in_ready=0, w_en=0, busy=0, done=0, w_addr=0, w_data=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; no write strobe in the cycle after reset deasserts.

Structure
REQ-032 State encodings and default WORD/DEPTH SHALL live in the shared filter package used with the read-side address generator.
REQ-033 FIFO SHALL be one sub-module, sync_fifo (push/pop/full/empty, DEPTH entries of WORD bits); FSM and counters in output_writer.

Verification
REQ-034 Start h=3,w=3,base=0x010, in_valid always 1, mem_grant always 1 -> 9 writes at 0x010..0x018 in order, done one cycle after the 9th write.
REQ-035 Same frame, mem_grant=0 for 10 cycles -> exactly 4 accepts then in_ready=0; after grant, data order 0..8 intact.
REQ-036 base=0x1FE, h=1,w=4 -> addresses 0x1FE,0x1FF,0x000,0x001.
REQ-037 Start with h=0,w=5 -> no w_en, done pulses the cycle after start, back to IDLE.
REQ-038 Assert rst after 5 of 9 writes -> all outputs 0 immediately; new start h=2,w=2 writes from base address with write count 0.
REQ-039 Second start pulse during RUN -> ignored, latched total unchanged, frame completes normally.

Source files
------------

// File: rtl/output_writer_pkg.sv
// output_writer_pkg
//   Shared definitions for the filter output side: default pixel/dimension
//   width, default elastic FIFO depth and the writer FSM state encoding.
//   The read-side address generator uses the same defaults.
package output_writer_pkg;

  localparam int OW_WORD_DEF  = 8;
  localparam int OW_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ow_state_e;

  // States in which the FIFO may be popped into output memory.
  function automatic logic is_active(input ow_state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/output_writer_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO of DEPTH entries of WIDTH bits (DEPTH a power of two,
//   at least 2). Push is ignored when full, pop is ignored when empty; a
//   simultaneous push and pop both take effect. No bypass: a word pushed in
//   a cycle is visible at data_o at the earliest in the following cycle.
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset (empties FIFO)
//   push_i     write data_i into the tail
//   pop_i      drop the head
//   data_i     write data
//   data_o     current head (valid when empty_o is low)
//   full_o     DEPTH entries held
//   empty_o    no entries held
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only observed behind empty_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/output_writer.sv
// output_writer
//   Collects h*w filtered pixels from the filter core through an elastic
//   FIFO and writes them to consecutive output-memory addresses starting at
//   base_addr (addresses wrap modulo 2^(WORD+1)), whenever the shared memory
//   port is granted.
//   Handshakes: an input pixel is accepted in a cycle where in_valid and
//   in_ready are both high; a memory write happens in a cycle where w_en is
//   high (FIFO non-empty, writer active, mem_grant high). Neither side may
//   assume the other holds its signals beyond that single cycle.
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        one-cycle pulse, honoured only in IDLE
//   h, w         frame height/width, sampled at start
//   base_addr    first output address, sampled at start
//   in_data/in_valid/in_ready   pixel stream from the filter core
//   mem_grant    memory port granted this cycle
//   w_addr/w_data/w_en          output-memory write port
//   busy         high in RUN and DRAIN
//   done         one-cycle pulse after the last pixel is written
//   dbg_state    current FSM state
module output_writer
  import output_writer_pkg::*;
#(
  parameter int WORD  = OW_WORD_DEF,
  parameter int DEPTH = OW_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WORD-1:0] h,
  input  logic [WORD-1:0] w,
  input  logic [WORD:0]   base_addr,
  input  logic [WORD-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_grant,
  output logic [WORD:0]   w_addr,
  output logic [WORD-1:0] w_data,
  output logic            w_en,
  output logic            busy,
  output logic            done,
  output ow_state_e       dbg_state
);

  localparam int TW = 2 * WORD;

  ow_state_e       state_q, state_d;
  logic [TW-1:0]   total_q, total_d;
  logic [TW-1:0]   acc_q, acc_d;
  logic [TW-1:0]   wr_q, wr_d;
  logic [WORD:0]   base_q, base_d;
  logic [WORD:0]   last_addr_q, last_addr_d;
  logic [WORD-1:0] last_data_q, last_data_d;

  logic            active;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [WORD-1:0] fifo_head;
  logic [WORD:0]   cur_addr;

  assign active   = is_active(state_q);
  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = active && !fifo_empty && mem_grant;
  // Truncation to WORD+1 bits gives the required address wrap-around.
  assign cur_addr = base_q + wr_q[WORD:0];

  assign w_en      = pop;
  // Outside an active frame the write port shows the last written pair.
  assign w_addr    = active ? cur_addr  : last_addr_q;
  assign w_data    = active ? fifo_head : last_data_q;
  assign busy      = active;
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

  sync_fifo #(
    .WIDTH (WORD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_data),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    base_d      = base_q;
    acc_d       = acc_q;
    wr_d        = wr_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;

    if (push) acc_d = acc_q + TW'(1);
    if (pop) begin
      wr_d        = wr_q + TW'(1);
      last_addr_d = cur_addr;
      last_data_d = fifo_head;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((h != '0) && (w != '0)) begin
            state_d = ST_RUN;
            total_d = TW'(h) * TW'(w);
            base_d  = base_addr;
            acc_d   = '0;
            wr_d    = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      // The last accept closes the input side; in_ready drops next cycle.
      ST_RUN:   if (push && (acc_d == total_q)) state_d = ST_DRAIN;
      // The final pop always lands here: no bypass means a pixel pushed in
      // RUN cannot be written in the same cycle.
      ST_DRAIN: if (pop && (wr_d == total_q)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      total_q     <= '0;
      base_q      <= '0;
      acc_q       <= '0;
      wr_q        <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      wr_q        <= wr_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

endmodule

// File: tb/tb_output_writer.sv
module tb_output_writer;
  import output_writer_pkg::*;

  localparam int WORD  = 8;
  localparam int DEPTH = 4;
  localparam int AW    = WORD + 1;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [WORD-1:0] h;
  logic [WORD-1:0] w;
  logic [AW-1:0]   base_addr;
  logic [WORD-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            mem_grant;
  logic [AW-1:0]   w_addr;
  logic [WORD-1:0] w_data;
  logic            w_en;
  logic            busy;
  logic            done;
  ow_state_e       dbg_state;

  always #5 clk = ~clk;

  output_writer #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .h         (h),
    .w         (w),
    .base_addr (base_addr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_grant (mem_grant),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_en      (w_en),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+WORD-1:0] exp_q[$];      // {address, pixel} in write order
  logic [AW-1:0]      g_last_addr = '0;
  logic [WORD-1:0]    g_last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            hh;
    int            ww;
    logic [AW-1:0] base;
    int            vpct;        // in_valid probability, percent
    int            gpct;        // mem_grant probability, percent
    int            stall;       // grant forced low for this many cycles
    int            stall_acc;   // accepts expected when the stall ends
    int            abort_at;    // assert rst after this many writes (-1: never)
    int            restart_at;  // cycle of a stray start pulse (-1: never)
    int            exp_writes;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic abort_frame();
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_w_en",     32'(w_en),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_w_addr",   32'(w_addr),   32'd0);
    check("rst_w_data",   32'(w_data),   32'd0);
    check("rst_state",    32'(dbg_state), 32'(ST_IDLE));
    in_valid  = 1'b1;
    mem_grant = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("w_en_after_rst", 32'(w_en), 32'd0);
    @(posedge clk); #1;
    exp_q.delete();
    g_last_addr = '0;
    g_last_data = '0;
  endtask

  // Reference model: the frame is a list of (base+i, pixel_i); the FIFO is
  // just the count of accepted-but-unwritten pixels.
  task automatic run_frame(input vec_t v, output int nw,
                           output logic [AW-1:0] fa, output logic [AW-1:0] la);
    int total = v.hh * v.ww;
    int idx = 0;
    int wrs = 0;
    int occ;
    bit fin = 0;
    bit aborted = 0;
    bit acc;
    bit exp_done;
    logic [WORD-1:0] pix[$];
    logic [AW-1:0] a;
    logic [AW+WORD-1:0] e;
    fa = '0;
    la = '0;
    exp_q.delete();
    for (int i = 0; i < total; i++) begin
      pix.push_back(WORD'($urandom_range(0, 255)));
      a = v.base + AW'(i);
      exp_q.push_back({a, pix[i]});
    end
    h = WORD'(v.hh); w = WORD'(v.ww); base_addr = v.base;
    start = 1'b1; in_valid = 1'b0; mem_grant = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (v.abort_at >= 0 && wrs == v.abort_at) begin
        abort_frame();
        fin = 1;
        aborted = 1;
      end else begin
        start = (cyc == v.restart_at);
        if (start) begin h = 1; w = 1; end
        in_valid  = (idx < total) && ($urandom_range(1, 100) <= v.vpct);
        in_data   = (idx < total) ? pix[idx] : WORD'($urandom);
        mem_grant = (cyc >= v.stall) && ($urandom_range(1, 100) <= v.gpct);
        @(negedge clk);
        exp_done = (wrs == total);
        occ = idx - wrs;
        check("done",     32'(done),     32'(exp_done));
        check("busy",     32'(busy),     32'(!exp_done));
        check("in_ready", 32'(in_ready), 32'(!exp_done && idx < total && occ < DEPTH));
        check("w_en",     32'(w_en),     32'(!exp_done && occ > 0 && mem_grant));
        if (v.stall > 0 && cyc == v.stall) check("acc_at_stall_end", idx, v.stall_acc);
        if (w_en) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_write: addr 0x%0h data 0x%0h with nothing expected", w_addr, w_data);
          end else begin
            e = exp_q.pop_front();
            check("w_addr", 32'(w_addr), 32'(e[AW+WORD-1:WORD]));
            check("w_data", 32'(w_data), 32'(e[WORD-1:0]));
            g_last_addr = e[AW+WORD-1:WORD];
            g_last_data = e[WORD-1:0];
          end
          if (wrs == 0) fa = w_addr;
          la = w_addr;
          wrs++;
        end
        if (exp_done) fin = 1;
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        if (acc) idx++;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL frame_timeout: %0d writes of %0d", wrs, total);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      exp_q.delete(); g_last_addr = '0; g_last_data = '0;
    end else if (!aborted) begin
      check("leftover_expected", exp_q.size(), 32'd0);
    end
    nw = wrs;
  endtask

  // One IDLE cycle: no handshake, outputs hold the last written pair.
  task automatic idle_check();
    in_valid = 1'b1; mem_grant = 1'b1; in_data = WORD'($urandom);
    @(negedge clk);
    check("idle_state",    32'(dbg_state), 32'(ST_IDLE));
    check("idle_done",     32'(done),      32'd0);
    check("idle_busy",     32'(busy),      32'd0);
    check("idle_w_en",     32'(w_en),      32'd0);
    check("idle_in_ready", 32'(in_ready),  32'd0);
    check("idle_w_addr",   32'(w_addr),    32'(g_last_addr));
    check("idle_w_data",   32'(w_data),    32'(g_last_data));
    @(posedge clk); #1;
    in_valid = 1'b0; mem_grant = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[9];
    vec_t rv;
    int nw;
    logic [AW-1:0] fa, la;

    //          h  w  base    v%   g%   stall acc abort rst#  writes first   last
    vecs[0] = '{3, 3, 9'h010, 100, 100, 0,    0,  -1,   -1,   9,     9'h010, 9'h018};
    vecs[1] = '{3, 3, 9'h010, 100, 100, 10,   4,  -1,   -1,   9,     9'h010, 9'h018};
    vecs[2] = '{1, 4, 9'h1FE, 100, 100, 0,    0,  -1,   -1,   4,     9'h1FE, 9'h001};
    vecs[3] = '{0, 5, 9'h033, 100, 100, 0,    0,  -1,   -1,   0,     9'h000, 9'h000};
    vecs[4] = '{3, 3, 9'h020, 100, 100, 0,    0,  5,    -1,   5,     9'h020, 9'h024};
    vecs[5] = '{2, 2, 9'h040, 100, 100, 0,    0,  -1,   -1,   4,     9'h040, 9'h043};
    vecs[6] = '{2, 3, 9'h100, 100, 100, 0,    0,  -1,   2,    6,     9'h100, 9'h105};
    vecs[7] = '{5, 2, 9'h0F0, 50,  50,  0,    0,  -1,   -1,   10,    9'h0F0, 9'h0F9};
    vecs[8] = '{4, 0, 9'h077, 100, 100, 0,    0,  -1,   -1,   0,     9'h000, 9'h000};

    rst = 1'b1; start = 1'b0; h = '0; w = '0; base_addr = '0;
    in_data = '0; in_valid = 1'b0; mem_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",    32'(dbg_state), 32'(ST_IDLE));
    check("reset_in_ready", 32'(in_ready),  32'd0);
    check("reset_w_en",     32'(w_en),      32'd0);
    check("reset_busy",     32'(busy),      32'd0);
    check("reset_done",     32'(done),      32'd0);
    check("reset_w_addr",   32'(w_addr),    32'd0);
    check("reset_w_data",   32'(w_data),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i], nw, fa, la);
      check($sformatf("vec%0d_writes", i), nw, vecs[i].exp_writes);
      if (vecs[i].exp_writes > 0) begin
        check($sformatf("vec%0d_first_addr", i), 32'(fa), 32'(vecs[i].exp_first));
        check($sformatf("vec%0d_last_addr", i),  32'(la), 32'(vecs[i].exp_last));
      end
      idle_check();
    end

    for (int i = 0; i < 25; i++) begin
      rv.hh = $urandom_range(0, 4);
      rv.ww = $urandom_range(0, 5);
      rv.base = AW'($urandom_range(0, 511));
      rv.vpct = $urandom_range(20, 100);
      rv.gpct = $urandom_range(20, 100);
      rv.stall = $urandom_range(0, 6);
      rv.stall_acc = 0;
      rv.abort_at = -1;
      rv.restart_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : -1;
      rv.exp_writes = rv.hh * rv.ww;
      rv.exp_first = rv.base;
      rv.exp_last = rv.base + AW'(rv.exp_writes - 1);
      // Stall-end accept count is only known for a fully-valid stream.
      if (rv.stall > 0 && rv.vpct == 100) begin
        rv.stall_acc = (rv.exp_writes < DEPTH) ? rv.exp_writes : DEPTH;
        if (rv.stall < rv.stall_acc) rv.stall_acc = rv.stall;
      end else begin
        rv.stall = (rv.vpct == 100) ? rv.stall : 0;
      end
      run_frame(rv, nw, fa, la);
      check($sformatf("rand%0d_writes", i), nw, rv.exp_writes);
      if (rv.exp_writes > 0) begin
        check($sformatf("rand%0d_first_addr", i), 32'(fa), 32'(rv.exp_first));
        check($sformatf("rand%0d_last_addr", i),  32'(la), 32'(rv.exp_last));
      end
      idle_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
